// File: rtl/ts_capture_arbiter.sv
// Timestamp capture arbiter: per-source event hold registers, round-robin grant
// into a first-word-fall-through record FIFO, with overrun flags and drop statistics.
`timescale 1ns/1ps
module ts_capture_arbiter #(
   parameter int N_REQ      = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int TS_W       = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [N_REQ-1:0]  req,
   input  logic [TS_W-1:0]   timestamp,
   input  logic              ts_valid,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [TS_W-1:0]   out_ts,
   output logic [2:0]        out_src,
   output logic              out_ts_invalid,
   output logic              out_overrun,
   output logic [N_REQ-1:0]  pending,
   output logic              fifo_full,
   output logic [15:0]       drop_count,
   input  logic              clr_stats
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [3:0]    NREQ_C   = 4'(N_REQ);
   localparam logic [2:0]    LAST_RST = 3'(N_REQ - 1);

   function automatic logic [3:0] popcount(input logic [N_REQ-1:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < N_REQ; i++) begin
         c = c + {3'b000, v[i]};
      end
      return c;
   endfunction

   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {13'd0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   logic [N_REQ-1:0]  pending_q, pending_d;
   logic [N_REQ-1:0]  ovr_q, ovr_d;
   logic [TS_W-1:0]   hold_ts_q [N_REQ];
   logic [TS_W-1:0]   hold_ts_d [N_REQ];
   logic [N_REQ-1:0]  hold_inv_q, hold_inv_d;
   logic [N_REQ-1:0]  hold_ovr_q, hold_ovr_d;
   logic [2:0]        last_grant_q, last_grant_d;
   logic [TS_W-1:0]   mem_ts_q [FIFO_DEPTH];
   logic [TS_W-1:0]   mem_ts_d [FIFO_DEPTH];
   logic [2:0]        mem_src_q [FIFO_DEPTH];
   logic [2:0]        mem_src_d [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] mem_inv_q, mem_inv_d;
   logic [FIFO_DEPTH-1:0] mem_ovr_q, mem_ovr_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              out_valid_q, out_valid_d;
   logic              fifo_full_q, fifo_full_d;
   logic [15:0]       drop_count_q, drop_count_d;

   logic [N_REQ-1:0]  cap_s, drop_s, take_s, grant_vec_s;
   logic              grant_any_s, pop_s;
   logic [2:0]        grant_idx_s;
   logic [3:0]        search_idx_s;
   logic [TS_W-1:0]   rec_ts_s;
   logic              rec_inv_s, rec_ovr_s;

   // Round-robin grant starting after the last granted source; only while the FIFO has room.
   always_comb begin
      grant_vec_s  = {N_REQ{1'b0}};
      grant_any_s  = 1'b0;
      grant_idx_s  = 3'd0;
      search_idx_s = 4'd0;
      if (count_q != DEPTH_C) begin
         for (int k = 0; k < N_REQ; k++) begin
            search_idx_s = {1'b0, last_grant_q} + 4'd1 + 4'(k);
            if (search_idx_s >= NREQ_C) begin
               search_idx_s = search_idx_s - NREQ_C;
            end else begin
               search_idx_s = search_idx_s;
            end
            for (int i = 0; i < N_REQ; i++) begin
               if (!grant_any_s && pending_q[i] && (search_idx_s == 4'(i))) begin
                  grant_any_s    = 1'b1;
                  grant_idx_s    = 3'(i);
                  grant_vec_s[i] = 1'b1;
               end else begin
                  grant_any_s    = grant_any_s;
               end
            end
         end
      end else begin
         grant_any_s = 1'b0;
      end
   end

   // Per-source capture/drop decisions and hold-register next state.
   always_comb begin
      cap_s     = req & {N_REQ{enable}};
      drop_s    = cap_s & pending_q & ~grant_vec_s;
      take_s    = cap_s & (~pending_q | grant_vec_s);
      pending_d = (pending_q & ~grant_vec_s) | take_s;
      // A push reports the outstanding overrun, so the flag restarts with that push.
      ovr_d     = (ovr_q & ~grant_vec_s) | drop_s;
      hold_inv_d = hold_inv_q;
      hold_ovr_d = hold_ovr_q;
      for (int i = 0; i < N_REQ; i++) begin
         if (take_s[i]) begin
            hold_ts_d[i]  = timestamp;
            hold_inv_d[i] = ~ts_valid;
            hold_ovr_d[i] = ovr_d[i];
         end else begin
            hold_ts_d[i]  = hold_ts_q[i];
         end
      end
      last_grant_d = grant_any_s ? grant_idx_s : last_grant_q;
      drop_count_d = sat_add(clr_stats ? 16'd0 : drop_count_q, popcount(drop_s));
   end

   // Select the granted hold register as the record to push.
   always_comb begin
      rec_ts_s  = {TS_W{1'b0}};
      rec_inv_s = 1'b0;
      rec_ovr_s = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_vec_s[i]) begin
            rec_ts_s  = hold_ts_q[i];
            rec_inv_s = hold_inv_q[i];
            rec_ovr_s = hold_ovr_q[i] | ovr_q[i];
         end else begin
            rec_ts_s  = rec_ts_s;
         end
      end
   end

   // FIFO write, pointer and occupancy next state.
   always_comb begin
      pop_s     = out_valid_q & out_ready;
      mem_ts_d  = mem_ts_q;
      mem_src_d = mem_src_q;
      mem_inv_d = mem_inv_q;
      mem_ovr_d = mem_ovr_q;
      if (grant_any_s) begin
         mem_ts_d[wr_ptr_q]  = rec_ts_s;
         mem_src_d[wr_ptr_q] = grant_idx_s;
         mem_inv_d[wr_ptr_q] = rec_inv_s;
         mem_ovr_d[wr_ptr_q] = rec_ovr_s;
         wr_ptr_d            = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d            = wr_ptr_q;
      end
      rd_ptr_d = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({grant_any_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      out_valid_d = (count_d != {CW{1'b0}});
      fifo_full_d = (count_d == DEPTH_C);
   end

   // State registers; reset discards all holds and FIFO contents at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q    <= {N_REQ{1'b0}};
         ovr_q        <= {N_REQ{1'b0}};
         hold_ts_q    <= '{default: '0};
         hold_inv_q   <= {N_REQ{1'b0}};
         hold_ovr_q   <= {N_REQ{1'b0}};
         last_grant_q <= LAST_RST;
         mem_ts_q     <= '{default: '0};
         mem_src_q    <= '{default: '0};
         mem_inv_q    <= {FIFO_DEPTH{1'b0}};
         mem_ovr_q    <= {FIFO_DEPTH{1'b0}};
         wr_ptr_q     <= {AW{1'b0}};
         rd_ptr_q     <= {AW{1'b0}};
         count_q      <= {CW{1'b0}};
         out_valid_q  <= 1'b0;
         fifo_full_q  <= 1'b0;
         drop_count_q <= 16'd0;
      end else begin
         pending_q    <= pending_d;
         ovr_q        <= ovr_d;
         hold_ts_q    <= hold_ts_d;
         hold_inv_q   <= hold_inv_d;
         hold_ovr_q   <= hold_ovr_d;
         last_grant_q <= last_grant_d;
         mem_ts_q     <= mem_ts_d;
         mem_src_q    <= mem_src_d;
         mem_inv_q    <= mem_inv_d;
         mem_ovr_q    <= mem_ovr_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         out_valid_q  <= out_valid_d;
         fifo_full_q  <= fifo_full_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_ts         = mem_ts_q[rd_ptr_q];
   assign out_src        = mem_src_q[rd_ptr_q];
   assign out_ts_invalid = mem_inv_q[rd_ptr_q];
   assign out_overrun    = mem_ovr_q[rd_ptr_q];
   assign pending        = pending_q;
   assign fifo_full      = fifo_full_q;
   assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_ts_capture_arbiter.sv
// Directed bench for ts_capture_arbiter: capture latency, round-robin, overrun,
// enable gating, drop saturation/clear and asynchronous reset.
`timescale 1ns/1ps
module tb_ts_capture_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [3:0]  req;
   logic [63:0] timestamp;
   logic        ts_valid;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_ts;
   logic [2:0]  out_src;
   logic        out_ts_invalid;
   logic        out_overrun;
   logic [3:0]  pending;
   logic        fifo_full;
   logic [15:0] drop_count;
   logic        clr_stats;

   int pass_cnt = 0;
   int total_cnt = 0;

   ts_capture_arbiter #(.N_REQ(4), .FIFO_DEPTH(8), .TS_W(64)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .timestamp(timestamp),
      .ts_valid(ts_valid), .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts),
      .out_src(out_src), .out_ts_invalid(out_ts_invalid), .out_overrun(out_overrun),
      .pending(pending), .fifo_full(fifo_full), .drop_count(drop_count), .clr_stats(clr_stats)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in cycle 0: inputs set now are sampled by the first live edge.
   task automatic do_reset();
      rst_n = 1'b0; enable = 1'b1; req = 4'b0000; timestamp = 64'h0;
      ts_valid = 1'b1; out_ready = 1'b1; clr_stats = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %0b expected 0", out_valid); else pass_cnt++;
      total_cnt++; if (pending !== 4'b0000) $display("FAIL rst_pending: got %b expected 0000", pending); else pass_cnt++;
      total_cnt++; if (fifo_full !== 1'b0) $display("FAIL rst_full: got %0b expected 0", fifo_full); else pass_cnt++;
      total_cnt++; if (drop_count !== 16'd0) $display("FAIL rst_drops: got %0d expected 0", drop_count); else pass_cnt++;
   endtask

   task automatic test_single();
      do_reset();
      timestamp = 64'h100; req = 4'b0001;
      step();
      req = 4'b0000;
      total_cnt++; if (pending !== 4'b0001) $display("FAIL single_pending: got %b expected 0001", pending); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL single_early: got %0b expected 0", out_valid); else pass_cnt++;
      step();
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %0b expected 1", out_valid); else pass_cnt++;
      total_cnt++; if (out_ts !== 64'h100) $display("FAIL single_ts: got %h expected 100", out_ts); else pass_cnt++;
      total_cnt++; if (out_src !== 3'd0) $display("FAIL single_src: got %0d expected 0", out_src); else pass_cnt++;
      total_cnt++; if ({out_ts_invalid, out_overrun} !== 2'b00) $display("FAIL single_flags: got %b expected 00", {out_ts_invalid, out_overrun}); else pass_cnt++;
      step();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL single_drained: got %0b expected 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_simultaneous();
      do_reset();
      timestamp = 64'h200; req = 4'b1111;
      step();
      req = 4'b0000;
      step();
      for (int k = 0; k < 4; k++) begin
         total_cnt++; if (out_valid !== 1'b1) $display("FAIL rr_valid[%0d]: got %0b expected 1", k, out_valid); else pass_cnt++;
         total_cnt++; if (out_src !== 3'(k)) $display("FAIL rr_src[%0d]: got %0d expected %0d", k, out_src, k); else pass_cnt++;
         total_cnt++; if (out_ts !== 64'h200) $display("FAIL rr_ts[%0d]: got %h expected 200", k, out_ts); else pass_cnt++;
         step();
      end
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rr_empty: got %0b expected 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_overrun();
      do_reset();
      out_ready = 1'b0;
      for (int p = 0; p < 10; p++) begin
         req = 4'b0010; timestamp = 64'h1000 + 64'(p);
         step();
         req = 4'b0000;
         step();
      end
      total_cnt++; if (fifo_full !== 1'b1) $display("FAIL ovr_full: got %0b expected 1", fifo_full); else pass_cnt++;
      total_cnt++; if (pending !== 4'b0010) $display("FAIL ovr_pending: got %b expected 0010", pending); else pass_cnt++;
      total_cnt++; if (drop_count !== 16'd1) $display("FAIL ovr_drops: got %0d expected 1", drop_count); else pass_cnt++;
      out_ready = 1'b1;
      for (int r = 0; r < 9; r++) begin
         total_cnt++; if (out_valid !== 1'b1) $display("FAIL ovr_valid[%0d]: got %0b expected 1", r, out_valid); else pass_cnt++;
         total_cnt++; if (out_src !== 3'd1) $display("FAIL ovr_src[%0d]: got %0d expected 1", r, out_src); else pass_cnt++;
         total_cnt++; if (out_ts !== 64'h1000 + 64'(r)) $display("FAIL ovr_ts[%0d]: got %h expected %h", r, out_ts, 64'h1000 + 64'(r)); else pass_cnt++;
         total_cnt++; if (out_overrun !== (r == 8)) $display("FAIL ovr_flag[%0d]: got %0b expected %0b", r, out_overrun, (r == 8)); else pass_cnt++;
         step();
      end
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL ovr_empty: got %0b expected 0", out_valid); else pass_cnt++;
      total_cnt++; if (fifo_full !== 1'b0) $display("FAIL ovr_notfull: got %0b expected 0", fifo_full); else pass_cnt++;
   endtask

   task automatic test_ts_invalid_enable();
      do_reset();
      ts_valid = 1'b0; timestamp = 64'h300; req = 4'b0100;
      step();
      req = 4'b0000; ts_valid = 1'b1;
      step();
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL inv_valid: got %0b expected 1", out_valid); else pass_cnt++;
      total_cnt++; if (out_src !== 3'd2) $display("FAIL inv_src: got %0d expected 2", out_src); else pass_cnt++;
      total_cnt++; if (out_ts_invalid !== 1'b1) $display("FAIL inv_flag: got %0b expected 1", out_ts_invalid); else pass_cnt++;
      step();
      req = 4'b0001;
      step();
      enable = 1'b0;
      step();
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL en_drain_valid: got %0b expected 1", out_valid); else pass_cnt++;
      total_cnt++; if (out_src !== 3'd0) $display("FAIL en_drain_src: got %0d expected 0", out_src); else pass_cnt++;
      total_cnt++; if (pending !== 4'b0000) $display("FAIL en_ignored: got %b expected 0000", pending); else pass_cnt++;
      req = 4'b1111;
      repeat (3) step();
      req = 4'b0000;
      step();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL en_norec: got %0b expected 0", out_valid); else pass_cnt++;
      total_cnt++; if (pending !== 4'b0000) $display("FAIL en_nopend: got %b expected 0000", pending); else pass_cnt++;
      total_cnt++; if (drop_count !== 16'd0) $display("FAIL en_nodrop: got %0d expected 0", drop_count); else pass_cnt++;
      enable = 1'b1;
   endtask

   task automatic test_saturation();
      do_reset();
      out_ready = 1'b0; req = 4'b1111;
      repeat (9) step();
      total_cnt++; if (drop_count !== 16'd24) $display("FAIL sat_fill: got %0d expected 24", drop_count); else pass_cnt++;
      total_cnt++; if (fifo_full !== 1'b1) $display("FAIL sat_full: got %0b expected 1", fifo_full); else pass_cnt++;
      step();
      total_cnt++; if (drop_count !== 16'd28) $display("FAIL sat_multi: got %0d expected 28", drop_count); else pass_cnt++;
      repeat (16376) step();
      total_cnt++; if (drop_count !== 16'd65532) $display("FAIL sat_near: got %0d expected 65532", drop_count); else pass_cnt++;
      step();
      total_cnt++; if (drop_count !== 16'hFFFF) $display("FAIL sat_hit: got %h expected ffff", drop_count); else pass_cnt++;
      step();
      total_cnt++; if (drop_count !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", drop_count); else pass_cnt++;
      req = 4'b0001; clr_stats = 1'b1;
      step();
      total_cnt++; if (drop_count !== 16'd1) $display("FAIL clr_drop: got %0d expected 1", drop_count); else pass_cnt++;
      req = 4'b0000;
      step();
      total_cnt++; if (drop_count !== 16'd0) $display("FAIL clr_only: got %0d expected 0", drop_count); else pass_cnt++;
      clr_stats = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0; req = 4'b0111;
      step();
      req = 4'b0000;
      repeat (3) step();
      req = 4'b0011;
      step();
      req = 4'b0000;
      total_cnt++; if (pending !== 4'b0011) $display("FAIL mid_pre_pending: got %b expected 0011", pending); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %0b expected 1", out_valid); else pass_cnt++;
      rst_n = 1'b0;
      #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_valid: got %0b expected 0", out_valid); else pass_cnt++;
      total_cnt++; if (pending !== 4'b0000) $display("FAIL mid_pending: got %b expected 0000", pending); else pass_cnt++;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1; out_ready = 1'b1;
      repeat (3) step();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_quiet: got %0b expected 0", out_valid); else pass_cnt++;
      timestamp = 64'h400; req = 4'b1000;
      step();
      req = 4'b0000;
      step();
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL mid_new_valid: got %0b expected 1", out_valid); else pass_cnt++;
      total_cnt++; if (out_src !== 3'd3) $display("FAIL mid_new_src: got %0d expected 3", out_src); else pass_cnt++;
      total_cnt++; if (out_ts !== 64'h400) $display("FAIL mid_new_ts: got %h expected 400", out_ts); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_overrun();
      test_ts_invalid_enable();
      test_saturation();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
